// File: rtl/io_input_conditioner_if.sv
// Board-input bundle between the raw DE-board pins and the data-memory IO inputs.
interface io_input_conditioner_if;
  logic [9:0] switchesRaw;
  logic [3:0] keysRaw;
  logic [3:0] clrKeys;
  logic [9:0] switches;
  logic [3:0] keys;
  logic [3:0] keyPressed;
  logic [3:0] keyEdge;

  modport master (
    output switchesRaw, keysRaw, clrKeys,
    input  switches, keys, keyPressed, keyEdge
  );

  modport slave (
    input  switchesRaw, keysRaw, clrKeys,
    output switches, keys, keyPressed, keyEdge
  );
endinterface

// File: rtl/io_input_conditioner.sv
// Synchronizes and debounces slide switches and push-buttons, and keeps
// sticky press flags plus a one-cycle press pulse for polling software.
module io_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_BITS        = 20
) (
  input logic               clk,
  input logic               reset,
  io_input_conditioner_if.slave io
);

  localparam int unsigned NumSw  = 10;
  localparam int unsigned NumKey = 4;
  localparam int unsigned NumCh  = NumSw + NumKey;
  localparam logic [CNT_BITS-1:0] CntMax = CNT_BITS'(DEBOUNCE_CYCLES - 1);

  logic [NumCh-1:0]    sync1;
  logic [NumCh-1:0]    sync2;
  logic [NumCh-1:0]    stable;
  logic [CNT_BITS-1:0] cnt [NumCh];
  logic [NumKey-1:0]   keyPressedQ;
  logic [NumKey-1:0]   keyEdgeQ;

  logic [NumCh-1:0]    rawNorm_c;
  logic [NumCh-1:0]    stableNext_c;
  logic [CNT_BITS-1:0] cntNext_c [NumCh];
  logic [NumKey-1:0]   pressEvt_c;

  // Keys are active-low on the board; invert so every channel is active-high.
  assign rawNorm_c = {~io.keysRaw, io.switchesRaw};

  // Per-channel debounce: a differing level must persist DEBOUNCE_CYCLES edges.
  always_comb begin
    stableNext_c = stable;
    for (int unsigned i = 0; i < NumCh; i++) begin
      cntNext_c[i] = '0;
      if (sync2[i] != stable[i]) begin
        if (cnt[i] == CntMax) begin
          stableNext_c[i] = sync2[i];
        end else begin
          cntNext_c[i] = cnt[i] + CNT_BITS'(1);
        end
      end
    end
    pressEvt_c = stableNext_c[NumCh-1 -: NumKey] & ~stable[NumCh-1 -: NumKey];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1       <= '0;
      sync2       <= '0;
      stable      <= '0;
      keyPressedQ <= '0;
      keyEdgeQ    <= '0;
      for (int unsigned i = 0; i < NumCh; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1    <= rawNorm_c;
      sync2    <= sync1;
      stable   <= stableNext_c;
      keyEdgeQ <= pressEvt_c;
      // A press on the same edge as a clear keeps the flag set.
      keyPressedQ <= (keyPressedQ & ~io.clrKeys) | pressEvt_c;
      for (int unsigned i = 0; i < NumCh; i++) begin
        cnt[i] <= cntNext_c[i];
      end
    end
  end

  assign io.switches   = stable[NumSw-1:0];
  assign io.keys       = stable[NumCh-1 -: NumKey];
  assign io.keyPressed = keyPressedQ;
  assign io.keyEdge    = keyEdgeQ;

endmodule

// File: tb/tb_io_input_conditioner.sv
// Directed bench for io_input_conditioner with DEBOUNCE_CYCLES=4; expected
// outputs are queued per cycle and checked by an independent monitor.
module tb_io_input_conditioner;

  typedef struct {
    int         cyc;
    logic [9:0] sw;
    logic [3:0] k;
    logic [3:0] kp;
    logic [3:0] ke;
    string      name;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   failures;
  exp_t q[$];

  io_input_conditioner_if bus();

  io_input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_BITS(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .io(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expectAt(input int off, input logic [9:0] sw, input logic [3:0] k,
                          input logic [3:0] kp, input logic [3:0] ke, input string name);
    exp_t e;
    e.cyc  = cyc + off;
    e.sw   = sw;
    e.k    = k;
    e.kp   = kp;
    e.ke   = ke;
    e.name = name;
    q.push_back(e);
  endtask

  // Monitor: compares every queued expectation against the outputs after its edge.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (e.cyc != cyc) begin
        failures++;
        $display("FAIL %s: check for cycle %0d missed (now %0d)", e.name, e.cyc, cyc);
      end else if (bus.switches !== e.sw || bus.keys !== e.k ||
                   bus.keyPressed !== e.kp || bus.keyEdge !== e.ke) begin
        failures++;
        $display("FAIL %s @%0d: got sw=%h k=%h kp=%h ke=%h, want sw=%h k=%h kp=%h ke=%h",
                 e.name, cyc, bus.switches, bus.keys, bus.keyPressed, bus.keyEdge,
                 e.sw, e.k, e.kp, e.ke);
      end
    end
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    checks   = 0;
    failures = 0;
    reset           = 1'b1;
    bus.keysRaw     = 4'h0;
    bus.switchesRaw = 10'h3FF;
    bus.clrKeys     = 4'h0;

    // Reset with all inputs active, then acceptance after release.
    expectAt(1, 10'h000, 4'h0, 4'h0, 4'h0, "rst_edge1");
    expectAt(2, 10'h000, 4'h0, 4'h0, 4'h0, "rst_edge2");
    tick(2);
    reset = 1'b0;
    expectAt(5, 10'h000, 4'h0, 4'h0, 4'h0, "rst_pre_accept");
    expectAt(6, 10'h3FF, 4'hF, 4'hF, 4'hF, "rst_accept");
    expectAt(7, 10'h3FF, 4'hF, 4'hF, 4'h0, "rst_edge_drop");
    tick(8);

    bus.keysRaw     = 4'hF;
    bus.switchesRaw = 10'h000;
    expectAt(5, 10'h3FF, 4'hF, 4'hF, 4'h0, "release_all_pre");
    expectAt(6, 10'h000, 4'h0, 4'hF, 4'h0, "release_all");
    tick(8);
    bus.clrKeys = 4'hF;
    expectAt(1, 10'h000, 4'h0, 4'h0, 4'h0, "clear_all");
    tick(1);
    bus.clrKeys = 4'h0;

    // Clean press and release of key0.
    bus.keysRaw = 4'hE;
    expectAt(5, 10'h000, 4'h0, 4'h0, 4'h0, "press_pre");
    expectAt(6, 10'h000, 4'h1, 4'h1, 4'h1, "press_accept");
    expectAt(7, 10'h000, 4'h1, 4'h1, 4'h0, "press_pulse_end");
    tick(8);
    bus.keysRaw = 4'hF;
    expectAt(5, 10'h000, 4'h1, 4'h1, 4'h0, "release_pre");
    expectAt(6, 10'h000, 4'h0, 4'h1, 4'h0, "release_sticky");
    tick(8);

    // Bounce, then settle pressed.
    bus.keysRaw = 4'hE; tick(1);
    bus.keysRaw = 4'hF; tick(1);
    bus.keysRaw = 4'hE; tick(1);
    bus.keysRaw = 4'hF; tick(1);
    bus.keysRaw = 4'hE;
    expectAt(5, 10'h000, 4'h0, 4'h1, 4'h0, "bounce_pre");
    expectAt(6, 10'h000, 4'h1, 4'h1, 4'h1, "bounce_accept");
    expectAt(7, 10'h000, 4'h1, 4'h1, 4'h0, "bounce_single_pulse");
    tick(8);

    // Three-cycle glitch while held is rejected.
    bus.keysRaw = 4'hF;
    expectAt(3, 10'h000, 4'h1, 4'h1, 4'h0, "glitch_3");
    expectAt(6, 10'h000, 4'h1, 4'h1, 4'h0, "glitch_6");
    expectAt(8, 10'h000, 4'h1, 4'h1, 4'h0, "glitch_8");
    tick(3);
    bus.keysRaw = 4'hE;
    tick(7);
    bus.keysRaw = 4'hF;
    expectAt(6, 10'h000, 4'h0, 4'h1, 4'h0, "glitch_release");
    tick(8);

    // Selective clear.
    bus.keysRaw = 4'hD;
    expectAt(6, 10'h000, 4'h2, 4'h3, 4'h2, "key1_press");
    tick(8);
    bus.keysRaw = 4'hF;
    expectAt(6, 10'h000, 4'h0, 4'h3, 4'h0, "key1_release");
    tick(8);
    bus.clrKeys = 4'h1;
    expectAt(1, 10'h000, 4'h0, 4'h2, 4'h0, "clear_bit0");
    tick(1);
    bus.clrKeys = 4'hF;
    expectAt(1, 10'h000, 4'h0, 4'h0, 4'h0, "clear_rest");
    tick(1);
    bus.clrKeys = 4'h0;

    // Clear on the same edge as a press acceptance: set wins.
    bus.keysRaw = 4'hD;
    expectAt(5, 10'h000, 4'h0, 4'h0, 4'h0, "setwin_pre");
    expectAt(6, 10'h000, 4'h2, 4'h2, 4'h2, "setwin_accept");
    expectAt(7, 10'h000, 4'h2, 4'h2, 4'h0, "setwin_hold");
    tick(5);
    bus.clrKeys = 4'h2;
    tick(1);
    bus.clrKeys = 4'h0;
    tick(2);
    bus.keysRaw = 4'hF;
    expectAt(6, 10'h000, 4'h0, 4'h2, 4'h0, "setwin_release");
    tick(8);

    // Switch glitch rejected, then a held pattern accepted.
    bus.switchesRaw = 10'h020;
    expectAt(4, 10'h000, 4'h0, 4'h2, 4'h0, "sw_glitch_4");
    expectAt(7, 10'h000, 4'h0, 4'h2, 4'h0, "sw_glitch_7");
    tick(2);
    bus.switchesRaw = 10'h000;
    tick(6);
    bus.switchesRaw = 10'h2A5;
    expectAt(5, 10'h000, 4'h0, 4'h2, 4'h0, "sw_pre");
    expectAt(6, 10'h2A5, 4'h0, 4'h2, 4'h0, "sw_accept");
    tick(8);

    // Reset while key0 is mid-debounce.
    bus.keysRaw = 4'hE;
    expectAt(3, 10'h2A5, 4'h0, 4'h2, 4'h0, "middeb_pre_reset");
    expectAt(4, 10'h000, 4'h0, 4'h0, 4'h0, "middeb_reset");
    tick(3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    checks++;
    if (dut.cnt[10] !== 3'd0) begin
      failures++;
      $display("FAIL middeb_counter: got cnt=%0d, want 0", dut.cnt[10]);
    end
    expectAt(2, 10'h000, 4'h0, 4'h0, 4'h0, "middeb_no_early");
    expectAt(5, 10'h000, 4'h0, 4'h0, 4'h0, "middeb_restart_pre");
    expectAt(6, 10'h2A5, 4'h1, 4'h1, 4'h1, "middeb_restart");
    expectAt(7, 10'h2A5, 4'h1, 4'h1, 4'h0, "middeb_pulse_end");
    tick(10);

    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
